// File: rtl/debug_slave_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : debug_slave_cmd_queue
// Purpose  : System-clock command unit for the JTAG debug slave. It
//            synchronises the TCK-domain update-DR / update-IR levels,
//            detects their rising edges and buffers each captured
//            {ir_in, sr} command in a small FIFO. Consumers drain the FIFO
//            with a valid/ready handshake.
// Ports    :
//   clk, reset          - system clock, synchronous active-high reset
//   ir_in, sr           - TCK-domain instruction / data shift register
//                         (quasi-static while vs_udr is high)
//   vs_udr, vs_uir      - asynchronous update-DR / update-IR levels
//   cmd_valid/ready     - head-of-queue handshake
//   cmd_ir, cmd_jdo     - head entry contents
//   ir_changed          - one-cycle pulse per synchronised update-IR
//   level               - number of occupied entries
//   overflow            - sticky "command dropped" flag
//   clear_overflow      - clears overflow (a drop in the same cycle wins)
// Revision : 1.0 - initial release
// ============================================================================
module debug_slave_cmd_queue #(
  parameter int IR_W        = 2,
  parameter int DR_W        = 38,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IR_W-1:0]            ir_in,
  input  logic [DR_W-1:0]            sr,
  input  logic                       vs_udr,
  input  logic                       vs_uir,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [IR_W-1:0]            cmd_ir,
  output logic [DR_W-1:0]            cmd_jdo,
  output logic                       ir_changed,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clear_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = IR_W + DR_W;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  // --------------------------------------------------------------------------
  // Synchronisers and edge detectors
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
  logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
  // fill_q marks which synchroniser stages hold a post-reset sample. The
  // reset-cleared zeros in the chains are not real observations of a low
  // input, so they must not arm the detectors; otherwise a level held high
  // across reset release would look like a fresh rising edge.
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   udr_prev_q, udr_prev_d;
  logic                   uir_prev_q, uir_prev_d;
  logic                   udr_armed_q, udr_armed_d;
  logic                   uir_armed_q, uir_armed_d;
  logic                   ir_changed_q, ir_changed_d;

  logic udr_s;
  logic uir_s;
  logic settled;
  logic udr_evt;
  logic uir_evt;

  always_comb begin
    udr_sync_d   = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    uir_sync_d   = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    fill_d       = {fill_q[SYNC_STAGES-2:0], 1'b1};

    udr_s        = udr_sync_q[SYNC_STAGES-1];
    uir_s        = uir_sync_q[SYNC_STAGES-1];
    settled      = fill_q[SYNC_STAGES-1];

    udr_prev_d   = udr_s;
    uir_prev_d   = uir_s;

    // A detector arms only after it has genuinely observed a low level.
    udr_armed_d  = udr_armed_q | (settled & ~udr_s);
    uir_armed_d  = uir_armed_q | (settled & ~uir_s);

    udr_evt      = udr_s & ~udr_prev_q & udr_armed_q;
    uir_evt      = uir_s & ~uir_prev_q & uir_armed_q;

    ir_changed_d = uir_evt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync_q   <= '0;
      uir_sync_q   <= '0;
      fill_q       <= '0;
      udr_prev_q   <= 1'b0;
      uir_prev_q   <= 1'b0;
      udr_armed_q  <= 1'b0;
      uir_armed_q  <= 1'b0;
      ir_changed_q <= 1'b0;
    end else begin
      udr_sync_q   <= udr_sync_d;
      uir_sync_q   <= uir_sync_d;
      fill_q       <= fill_d;
      udr_prev_q   <= udr_prev_d;
      uir_prev_q   <= uir_prev_d;
      udr_armed_q  <= udr_armed_d;
      uir_armed_q  <= uir_armed_d;
      ir_changed_q <= ir_changed_d;
    end
  end

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  // Registered copy of mem[rd_ptr]; it gives the head outputs a defined
  // reset value without having to reset the storage array.
  logic [ENT_W-1:0] head_q, head_d;

  logic [ENT_W-1:0] push_data;
  logic             valid;
  logic             pop;
  logic             push_ok;
  logic             drop;

  always_comb begin
    push_data = {ir_in, sr};
    valid     = (level_q != '0);
    pop       = valid & cmd_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok   = udr_evt & ((level_q != LVL_FULL) | pop);
    drop      = udr_evt & ~push_ok;

    wr_ptr_d  = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Set wins over clear.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    // Track what mem[rd_ptr] will hold after this edge. The slot being
    // written this cycle can become the new head (push into an empty FIFO,
    // or push while the last entry pops), so forward the write data there.
    // When the FIFO is about to be empty the head is don't-care: hold it.
    head_d = head_q;
    if (level_d != '0) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
        head_d = push_data;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      head_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      head_q     <= head_d;
    end
  end

  // Storage array is not reset; pointers and level define its contents.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cmd_valid  = valid;
  assign cmd_ir     = head_q[ENT_W-1:DR_W];
  assign cmd_jdo    = head_q[DR_W-1:0];
  assign ir_changed = ir_changed_q;
  assign level      = level_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: doc/debug_slave_cmd_queue.md
# debug_slave_cmd_queue

Parametrised sysclk-side command unit for the Nios II JTAG debug slave. It replaces the fixed two-bit-IR, 38-bit decoder with configurable IR and DR widths, and adds a FIFO that buffers captured JTAG update-DR commands. Consumers drain it with a valid/ready handshake, so back-to-back debugger scans are no longer lost while the CPU-side debug logic is busy. It sits between the TCK-domain debug slave shift logic (`sr`, `ir_in`, `vs_udr`, `vs_uir`) and the OCI break, ocimem and trace control consumers.

## Interface
Parameters:
- `IR_W`, default 2: virtual JTAG instruction width.
- `DR_W`, default 38: data shift register width (`jdo` width).
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, default 2: synchroniser flops on `vs_udr` and `vs_uir`; ≥2.

Ports:
- `clk`, in, 1: system clock. One clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `ir_in`, in, `IR_W`: instruction from the TCK domain. It is quasi-static while `vs_udr` is high.
- `sr`, in, `DR_W`: shift register contents. It is quasi-static while `vs_udr` is high.
- `vs_udr`, in, 1: update-DR level from the TCK domain; asynchronous.
- `vs_uir`, in, 1: update-IR level from the TCK domain; asynchronous.
- `cmd_valid`, out, 1: FIFO head is valid.
- `cmd_ready`, in, 1: the consumer accepts the head.
- `cmd_ir`, out, `IR_W`: IR of the head entry.
- `cmd_jdo`, out, `DR_W`: DR of the head entry.
- `ir_changed`, out, 1: one-cycle pulse on each synchronised update-IR.
- `level`, out, clog2(`DEPTH`)+1: number of occupied entries.
- `overflow`, out, 1: sticky flag; a command was dropped because the FIFO was full.
- `clear_overflow`, in, 1: clears `overflow`.

## Operation
- **Synchronisers.** `vs_udr` and `vs_uir` each pass through a `SYNC_STAGES`-flop chain. A further register holds the previous synchronised value for edge detection.
- **Arming.** Each edge detector has an `armed` bit. It is cleared by reset and set once the synchronised value is seen low. A rising edge produces an event only while armed.
  - Consequence: a level held high across reset release produces no event.
- **udr event.** On a udr event, push `{ir_in, sr}` sampled in that cycle.
- **uir event.** On a uir event, `ir_changed` is high for exactly one cycle. Nothing is pushed.
- **FIFO.** Circular buffer with a `DEPTH`-entry memory and read/write pointers of clog2(`DEPTH`) bits that wrap modulo `DEPTH`. `level` is tracked explicitly.
- **Push/pop rules.**
  - Pop occurs when `cmd_valid && cmd_ready`.
  - Push is accepted when `level < DEPTH`, or when `level == DEPTH` and a pop occurs in the same cycle.
  - Otherwise the push is dropped and `overflow` is set.
  - Simultaneous push and pop leaves `level` unchanged.
- **Overflow flag.** `clear_overflow` clears `overflow`. If a drop occurs in the same cycle as `clear_overflow`, set wins.
- **Output timing.** `cmd_ir` and `cmd_jdo` show `mem[rd_ptr]` whenever `cmd_valid` is high, and hold stable until popped. While `cmd_valid` is low their values are don't-care.
- **Reset state.** Reset has priority over all events. It empties the FIFO (pointers and `level` to 0, no flush handshake), and discards any queued commands. All synchroniser, previous-value and armed bits go to 0.

## Timing
- **Reset values:** `cmd_valid`=0, `level`=0, `overflow`=0, `ir_changed`=0. `cmd_ir` and `cmd_jdo` are 0 (memory need not be reset, but the head output register is).
- **Input latency.** Suppose `vs_udr` is first sampled high at edge k and the detector is armed. The push is written at edge k+`SYNC_STAGES`. `cmd_valid`=1 after that edge.
- **uir latency.** `ir_changed` rises after the same edge count, k+`SYNC_STAGES`, relative to `vs_uir`.
- **Throughput.** One pop per cycle. `cmd_valid` drops the cycle after the last entry pops, unless a push lands in the same cycle.
- **Push to empty FIFO.** The entry is visible at the head one cycle after the push edge. There is no bypass.
- **Minimum event spacing.** `vs_udr` must stay high for at least `SYNC_STAGES`+1 clk cycles and low for at least `SYNC_STAGES`+1 clk cycles. The TCK-domain state machine guarantees this.

## Test plan
- **Single update.** `ir_in`=2'b01, `sr`=38'h2A_DEAD_BEEF, pulse `vs_udr` high for 4 cycles with `cmd_ready`=1 → `cmd_valid` high for exactly 1 cycle, 2 edges after the first sampled high, carrying `cmd_ir`=1 and `cmd_jdo`=38'h2A_DEAD_BEEF. `level` returns to 0.
- **Fill and overflow.** `cmd_ready`=0; 5 udr events with `sr`=1..5 → `level`=4 and `overflow`=1. Raising `cmd_ready` then pops 1,2,3,4 in order, and 5 is absent.
- **Full with simultaneous pop.** FIFO full; `cmd_ready`=1 in the push cycle → `overflow` stays 0, `level` stays 4, and the new entry is popped last. Pointer wrap is covered across 10 such events.
- **uir and reset mid-operation.** A `vs_uir` pulse → one `ir_changed` pulse. With 3 entries queued, assert `reset` for 1 cycle while `vs_udr` is held high → `level`=0 and `cmd_valid`=0. No event is generated until `vs_udr` goes low then high again.
- **Overflow clear collision.** `clear_overflow` asserted alone → `overflow`=0 the next cycle. `clear_overflow` asserted in the same cycle as a drop → `overflow` stays 1.
